// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V execute datapath.
// Holds the ALU operation codes, forwarding selects, branch func3 codes and the
// ALUOp codes the ALU controller uses to pick an ALU operation.
package riscv_pkg;

  localparam int XLEN = 32;

  // ALU operation codes; any unlisted code yields a zero result
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  // Operand forwarding selects; 2'b11 falls back to the register value
  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_REG2 = 2'b11
  } fwd_sel_e;

  // Branch conditions carried in func3
  typedef enum logic [2:0] {
    F3_BEQ = 3'b000,
    F3_BNE = 3'b001,
    F3_BLT = 3'b100,
    F3_BGE = 3'b101
  } br_func3_e;

  // ALUOp classes produced by the decoder for the ALU controller
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/signed SLT, modulo 2^XLEN.
// Latency 0; no flow control.
// Ports: alu_control (op code), a/b (operands), result, zero (result == 0).
module alu
  import riscv_pkg::*;
(
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, branch/jump resolution, EX/MEM register.
// Latency: redirect is same-cycle combinational; results land in EX/MEM 1 cycle later.
// Backpressure: stall holds EX/MEM; flush (wins over stall) turns the entry into a bubble.
// Ports: ID/EX operands + controls in, forwarded MEM/WB data in, pc_redirect and
//        redirect_target out (combinational), *_q EX/MEM register fields out.
module ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      alu_control,
  input  logic            alu_src,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            mem_write_in,
  input  logic            mem_read_in,
  input  logic [1:0]      result_src_in,
  input  logic            branch_in,
  input  logic            jump_in,
  input  logic            jalr_in,
  input  logic [2:0]      func3_in,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] alu_result_q,
  output logic [XLEN-1:0] write_data_q,
  output logic [XLEN-1:0] pc_plus4_q,
  output logic [4:0]      rd_q,
  output logic [1:0]      result_src_q,
  output logic            reg_write_q,
  output logic            mem_write_q,
  output logic            mem_read_q,
  output logic            valid_q
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result_d;
  logic            alu_zero;
  logic            signed_lt;
  logic            br_cond;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_plus4_d;

  // Forwarding muxes; the 2'b11 code falls through to the register value
  always_comb begin
    case (forward_a)
      FWD_WB:  op_a = wb_fwd_data;
      FWD_MEM: op_a = mem_fwd_data;
      default: op_a = rs1_data;
    endcase
  end

  always_comb begin
    case (forward_b)
      FWD_WB:  fwd_b = wb_fwd_data;
      FWD_MEM: fwd_b = mem_fwd_data;
      default: fwd_b = rs2_data;
    endcase
  end

  assign op_b = alu_src ? imm : fwd_b;

  alu u_alu (
    .alu_control (alu_control),
    .a           (op_a),
    .b           (op_b),
    .result      (alu_result_d),
    .zero        (alu_zero)
  );

  // BLT/BGE use their own compare so SUB overflow cannot corrupt the decision
  assign signed_lt = $signed(op_a) < $signed(fwd_b);

  always_comb begin
    br_cond = 1'b0;
    case (func3_in)
      F3_BEQ:  br_cond = alu_zero;
      F3_BNE:  br_cond = ~alu_zero;
      F3_BLT:  br_cond = signed_lt;
      F3_BGE:  br_cond = ~signed_lt;
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_redirect = valid_in & ~flush & ((branch_in & br_cond) | jump_in | jalr_in);

  // JALR target drops bit 0; every other case (including no redirect) is pc + imm
  assign jalr_sum        = op_a + imm;
  assign redirect_target = (pc_redirect & jalr_in) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                   : (pc + imm);

  assign pc_plus4_d = pc + {{(XLEN-3){1'b0}}, 3'd4};

  // EX/MEM register. Data fields also load on flush; only the control bits
  // matter for a bubble, so this keeps the data enable simple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      result_src_q <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      if (flush || !stall) begin
        alu_result_q <= alu_result_d;
        write_data_q <= fwd_b;
        pc_plus4_q   <= pc_plus4_d;
        rd_q         <= rd_in;
        result_src_q <= result_src_in;
      end
      if (flush) begin
        reg_write_q <= 1'b0;
        mem_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        valid_q     <= 1'b0;
      end else if (!stall) begin
        reg_write_q <= reg_write_in & valid_in;
        mem_write_q <= mem_write_in & valid_in;
        mem_read_q  <= mem_read_in  & valid_in;
        valid_q     <= valid_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_control;
  logic        alu_src;
  logic [31:0] rs1_data, rs2_data, imm, pc, mem_fwd_data, wb_fwd_data;
  logic [1:0]  forward_a, forward_b, result_src_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_write_in, mem_read_in;
  logic        branch_in, jump_in, jalr_in, valid_in, stall, flush;
  logic [2:0]  func3_in;
  logic        pc_redirect;
  logic [31:0] redirect_target, alu_result_q, write_data_q, pc_plus4_q;
  logic [4:0]  rd_q;
  logic [1:0]  result_src_q;
  logic        reg_write_q, mem_write_q, mem_read_q, valid_q;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .alu_control(alu_control), .alu_src(alu_src),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .forward_a(forward_a), .forward_b(forward_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
    .mem_read_in(mem_read_in), .result_src_in(result_src_in),
    .branch_in(branch_in), .jump_in(jump_in), .jalr_in(jalr_in),
    .func3_in(func3_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target),
    .alu_result_q(alu_result_q), .write_data_q(write_data_q),
    .pc_plus4_q(pc_plus4_q), .rd_q(rd_q), .result_src_q(result_src_q),
    .reg_write_q(reg_write_q), .mem_write_q(mem_write_q),
    .mem_read_q(mem_read_q), .valid_q(valid_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model (plain arithmetic from the rules) -------
  function automatic logic [31:0] m_pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] wb, input logic [31:0] mem);
    if (s == 2'd1) return wb;
    if (s == 2'd2) return mem;
    return r;
  endfunction

  // signed less-than via offset-binary comparison
  function automatic logic m_lt(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd4) return a ^ b;
    if (op == 3'd5) return m_lt(a, b) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic clear_inputs();
    alu_control = 3'd0; alu_src = 1'b0; rs1_data = '0; rs2_data = '0;
    imm = '0; pc = '0; forward_a = 2'd0; forward_b = 2'd0;
    mem_fwd_data = '0; wb_fwd_data = '0; rd_in = '0;
    reg_write_in = 1'b0; mem_write_in = 1'b0; mem_read_in = 1'b0;
    result_src_in = 2'd0; branch_in = 1'b0; jump_in = 1'b0; jalr_in = 1'b0;
    func3_in = 3'd0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alu"}, alu_result_q, 32'd0);
    check({tag, ".wd"},  write_data_q, 32'd0);
    check({tag, ".pc4"}, pc_plus4_q, 32'd0);
    check({tag, ".rd"},  {27'd0, rd_q}, 32'd0);
    check({tag, ".rs"},  {30'd0, result_src_q}, 32'd0);
    check({tag, ".ctl"}, {28'd0, reg_write_q, mem_write_q, mem_read_q, valid_q}, 32'd0);
  endtask

  // model of the EX/MEM register for the random phase
  logic [31:0] e_alu, e_wd, e_pc4;
  logic [4:0]  e_rd;
  logic [1:0]  e_rs;
  logic        e_rw, e_mw, e_mr, e_v, e_known;

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ADD 5 + 7
    valid_in = 1'b1; rs1_data = 32'd5; rs2_data = 32'd7; reg_write_in = 1'b1;
    rd_in = 5'd9; pc = 32'h0000_0010; result_src_in = 2'd1;
    tick();
    check("add.alu", alu_result_q, 32'd12);
    check("add.valid", {31'd0, valid_q}, 32'd1);
    check("add.regw", {31'd0, reg_write_q}, 32'd1);
    check("add.rd", {27'd0, rd_q}, 32'd9);
    check("add.pc4", pc_plus4_q, 32'h14);
    check("add.rsrc", {30'd0, result_src_q}, 32'd1);

    // SLT signed, then SUB 0 - 1
    reg_write_in = 1'b0;
    alu_control = 3'b101; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
    tick();
    check("slt", alu_result_q, 32'd1);
    check("slt.regw", {31'd0, reg_write_q}, 32'd0);
    alu_control = 3'b001; rs1_data = 32'd0; rs2_data = 32'd1;
    tick();
    check("sub", alu_result_q, 32'hFFFF_FFFF);

    // forwarding: MEM into A, WB into B
    forward_a = 2'b10; mem_fwd_data = 32'd100; forward_b = 2'b01; wb_fwd_data = 32'd3;
    rs1_data = 32'd1000; rs2_data = 32'd2000;
    tick();
    check("fwd.alu", alu_result_q, 32'd97);
    check("fwd.wd", write_data_q, 32'd3);
    forward_a = 2'b11; forward_b = 2'b11; rs1_data = 32'd50; rs2_data = 32'd8;
    tick();
    check("fwd11.alu", alu_result_q, 32'd42);
    check("fwd11.wd", write_data_q, 32'd8);
    forward_a = 2'b00; forward_b = 2'b00;

    // BEQ equal operands
    branch_in = 1'b1; func3_in = 3'b000; alu_control = 3'b001;
    rs1_data = 32'd9; rs2_data = 32'd9; pc = 32'h40; imm = 32'hFFFF_FFF8;
    #1;
    check("beq.redir", {31'd0, pc_redirect}, 32'd1);
    check("beq.tgt", redirect_target, 32'h38);

    // BLT where SUB overflows
    func3_in = 3'b100; rs1_data = 32'h8000_0000; rs2_data = 32'd1;
    pc = 32'h100; imm = 32'h20;
    #1;
    check("blt.redir", {31'd0, pc_redirect}, 32'd1);
    check("blt.tgt", redirect_target, 32'h120);

    // BEQ with invalid slot
    func3_in = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; pc = 32'h40;
    imm = 32'hFFFF_FFF8; valid_in = 1'b0; reg_write_in = 1'b1;
    #1;
    check("beqinv.redir", {31'd0, pc_redirect}, 32'd0);
    check("beqinv.tgt", redirect_target, 32'h38);
    tick();
    check("beqinv.valid", {31'd0, valid_q}, 32'd0);
    check("beqinv.regw", {31'd0, reg_write_q}, 32'd0);

    // JALR
    clear_inputs();
    valid_in = 1'b1; jalr_in = 1'b1; alu_src = 1'b1; rs1_data = 32'h1001;
    imm = 32'd2; pc = 32'h200; reg_write_in = 1'b1; result_src_in = 2'd2;
    #1;
    check("jalr.redir", {31'd0, pc_redirect}, 32'd1);
    check("jalr.tgt", redirect_target, 32'h1002);
    tick();
    check("jalr.pc4", pc_plus4_q, 32'h204);

    // stall holds for 2 cycles
    clear_inputs();
    valid_in = 1'b1; rs1_data = 32'd5; rs2_data = 32'd7; reg_write_in = 1'b1;
    mem_write_in = 1'b1; rd_in = 5'd3;
    tick();
    check("pre.alu", alu_result_q, 32'd12);
    stall = 1'b1; rs1_data = 32'd77; rd_in = 5'd20; valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall.alu", alu_result_q, 32'd12);
      check("stall.rd", {27'd0, rd_q}, 32'd3);
      check("stall.ctl", {28'd0, reg_write_q, mem_write_q, mem_read_q, valid_q}, 32'hD);
    end
    flush = 1'b1; valid_in = 1'b1;
    tick();
    check("stflush.ctl", {28'd0, reg_write_q, mem_write_q, mem_read_q, valid_q}, 32'd0);

    // async reset mid-stream; redirect stays combinational
    clear_inputs();
    valid_in = 1'b1; rs1_data = 32'd1; rs2_data = 32'd2; pc = 32'h80; imm = 32'h4;
    reg_write_in = 1'b1; mem_read_in = 1'b1; rd_in = 5'd7; result_src_in = 2'd3;
    tick();
    check("prerst.valid", {31'd0, valid_q}, 32'd1);
    jump_in = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    check("midrst.redir", {31'd0, pc_redirect}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    tick();

    // randomized phase against the model
    e_alu = '0; e_wd = '0; e_pc4 = '0; e_rd = '0; e_rs = '0;
    e_rw = 1'b0; e_mw = 1'b0; e_mr = 1'b0; e_v = 1'b0; e_known = 1'b1;
    for (int it = 0; it < 400; it++) begin
      logic [31:0] a, fb, b, res, tgt;
      logic        taken, redir;
      alu_control = 3'($urandom_range(0, 7));
      alu_src = 1'($urandom);
      rs2_data = $urandom;
      rs1_data = ($urandom_range(0, 3) == 0) ? rs2_data : $urandom;
      imm = $urandom; pc = $urandom;
      forward_a = 2'($urandom); forward_b = 2'($urandom);
      mem_fwd_data = ($urandom_range(0, 3) == 0) ? rs2_data : $urandom;
      wb_fwd_data = $urandom;
      rd_in = 5'($urandom); result_src_in = 2'($urandom);
      reg_write_in = 1'($urandom); mem_write_in = 1'($urandom); mem_read_in = 1'($urandom);
      branch_in = 1'($urandom); jump_in = ($urandom_range(0, 5) == 0);
      jalr_in = ($urandom_range(0, 5) == 0);
      func3_in = 3'($urandom);
      valid_in = ($urandom_range(0, 4) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);

      a = m_pick(forward_a, rs1_data, wb_fwd_data, mem_fwd_data);
      fb = m_pick(forward_b, rs2_data, wb_fwd_data, mem_fwd_data);
      b = alu_src ? imm : fb;
      res = m_alu(alu_control, a, b);
      case (func3_in)
        3'b000:  taken = (res == 0);
        3'b001:  taken = (res != 0);
        3'b100:  taken = m_lt(a, fb);
        3'b101:  taken = !m_lt(a, fb);
        default: taken = 1'b0;
      endcase
      redir = valid_in && !flush && ((branch_in && taken) || jump_in || jalr_in);
      tgt = (redir && jalr_in) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
      #1;
      check("rnd.redir", {31'd0, pc_redirect}, {31'd0, redir});
      check("rnd.tgt", redirect_target, tgt);

      if (flush) begin
        e_rw = 1'b0; e_mw = 1'b0; e_mr = 1'b0; e_v = 1'b0; e_known = 1'b0;
      end else if (!stall) begin
        e_alu = res; e_wd = fb; e_pc4 = pc + 32'd4; e_rd = rd_in; e_rs = result_src_in;
        e_rw = reg_write_in && valid_in; e_mw = mem_write_in && valid_in;
        e_mr = mem_read_in && valid_in; e_v = valid_in; e_known = 1'b1;
      end
      tick();
      check("rnd.ctl", {28'd0, reg_write_q, mem_write_q, mem_read_q, valid_q},
            {28'd0, e_rw, e_mw, e_mr, e_v});
      if (e_known) begin
        check("rnd.alu", alu_result_q, e_alu);
        check("rnd.wd", write_data_q, e_wd);
        check("rnd.pc4", pc_plus4_q, e_pc4);
        check("rnd.rd_rs", {25'd0, rd_q, result_src_q}, {25'd0, e_rd, e_rs});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
